// File: rtl/csi2_raw10_unpacker.sv
// RAW10 unpacker: 40-bit packed groups (4 MSB bytes + shared LSB byte) to PX_PER_CLK pixels per AXI-Stream beat.
// Optional RAW10_LINE_CNT_EN adds a per-line pixel counter (line_len_o / line_len_vld_o).
module csi2_raw10_unpacker #(
  parameter int PX_PER_CLK = 1,
  parameter int PX_WIDTH   = 10
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
`ifdef RAW10_LINE_CNT_EN
  output logic [15:0]                      line_len_o,
  output logic                             line_len_vld_o,
`endif
  input  logic [39:0]                      pkt_i_tdata,
  input  logic                             pkt_i_tvalid,
  output logic                             pkt_i_tready,
  input  logic                             pkt_i_tlast,
  output logic [PX_PER_CLK*PX_WIDTH-1:0]   pkt_o_tdata,
  output logic                             pkt_o_tvalid,
  input  logic                             pkt_o_tready,
  output logic                             pkt_o_tlast
);

  localparam int NPH  = 4 / PX_PER_CLK;
  localparam int PH_W = (NPH > 1) ? $clog2(NPH) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NPH - 1);

  if (!(PX_PER_CLK == 1 || PX_PER_CLK == 2 || PX_PER_CLK == 4)) begin : g_bad_px
    $error("csi2_raw10_unpacker: PX_PER_CLK must be 1, 2 or 4");
  end
  if (PX_WIDTH != 10) begin : g_bad_w
    $error("csi2_raw10_unpacker: PX_WIDTH must be 10");
  end

  logic [39:0]     buf_data_q, buf_data_d;
  logic            buf_last_q, buf_last_d;
  logic            buf_valid_q, buf_valid_d;
  logic [PH_W-1:0] phase_q, phase_d;

  logic last_ph, out_hs, in_hs;

  assign last_ph      = (phase_q == LAST_PH);
  assign out_hs       = buf_valid_q && pkt_o_tready;
  // Only combinational path through the block: downstream ready to upstream ready.
  assign pkt_i_tready = !buf_valid_q || (pkt_o_tready && last_ph);
  assign in_hs        = pkt_i_tvalid && pkt_i_tready;

  always_comb begin
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    phase_d     = phase_q;
    if (out_hs) begin
      if (!last_ph) begin
        phase_d = phase_q + 1'b1;
      end else begin
        phase_d     = '0;
        buf_valid_d = 1'b0;
      end
    end
    // A load in the last-phase cycle overrides the drain, so there is no bubble.
    if (in_hs) begin
      buf_data_d  = pkt_i_tdata;
      buf_last_d  = pkt_i_tlast;
      buf_valid_d = 1'b1;
      phase_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      phase_q     <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
      phase_q     <= phase_d;
    end
  end

  logic [3:0][PX_WIDTH-1:0] px_all;

  for (genvar k = 0; k < 4; k++) begin : g_unpack
    assign px_all[k] = {buf_data_q[8*k +: 8], buf_data_q[32+2*k +: 2]};
  end

  for (genvar p = 0; p < PX_PER_CLK; p++) begin : g_omux
    logic [1:0] sel;
    assign sel = 2'(phase_q * PX_PER_CLK + p);
    assign pkt_o_tdata[p*PX_WIDTH +: PX_WIDTH] = px_all[sel];
  end

  assign pkt_o_tvalid = buf_valid_q;
  assign pkt_o_tlast  = buf_last_q && last_ph;

`ifdef RAW10_LINE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] line_len_q, line_len_d;
  logic        line_len_vld_q, line_len_vld_d;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_sat;

  assign cnt_sum = {1'b0, cnt_q} + 17'(PX_PER_CLK);
  assign cnt_sat = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  always_comb begin
    cnt_d          = cnt_q;
    line_len_d     = line_len_q;
    line_len_vld_d = 1'b0;
    if (out_hs) begin
      if (pkt_o_tlast) begin
        line_len_d     = cnt_sat;
        line_len_vld_d = 1'b1;
        cnt_d          = '0;
      end else begin
        cnt_d = cnt_sat;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q          <= '0;
      line_len_q     <= '0;
      line_len_vld_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      line_len_q     <= line_len_d;
      line_len_vld_q <= line_len_vld_d;
    end
  end

  assign line_len_o     = line_len_q;
  assign line_len_vld_o = line_len_vld_q;
`endif

endmodule

// File: doc/csi2_raw10_unpacker.md
Name: csi2_raw10_unpacker

Overview:
- Sits directly downstream of the CSI-2 RAW10 32b→40b gearbox.
- Consumes 40-bit packed RAW10 groups: four pixel MSB bytes followed by one shared LSB byte.
- Unpacks each group into 10-bit pixels and emits PX_PER_CLK pixels per output beat on an AXI4-Stream master.
- Preserves packet boundaries through tlast, and applies back-pressure so the gearbox can stall cleanly.

Parameters:
- PX_PER_CLK, 1, pixels per output beat; legal values 1, 2, 4; any other value is a compile-time error.
- PX_WIDTH, 10, bits per pixel; fixed at 10, exposed only for the output width calculation.

Ports:
- clk_i  input  1  single clock domain.
- rst_i  input  1  reset, synchronous, active-high.
- pkt_i  axi4_stream_if.slave  tdata 40, tvalid 1, tready 1, tlast 1  packed RAW10 groups from the gearbox.
- pkt_o  axi4_stream_if.master  tdata PX_PER_CLK*10, tvalid 1, tready 1, tlast 1  unpacked pixels; pixel n occupies tdata[10n+9:10n].
- line_len_o  output  16  only with RAW10_LINE_CNT_EN: pixel count of the last completed line.
- line_len_vld_o  output  1  only with RAW10_LINE_CNT_EN: one-cycle pulse when line_len_o updates.

Behaviour:
- Unpack rule: pixel k (k=0..3) = {tdata[8k+7:8k], tdata[32+2k+1:32+2k]}.
- Holding register buf_data[39:0], buf_last, buf_valid, and phase counter phase over 0..NPH-1, where NPH = 4/PX_PER_CLK.
- Reset values: buf_valid=0, phase=0, buf_data=0, buf_last=0, pkt_o.tvalid=0, pkt_o.tdata=0, pkt_o.tlast=0, line_len_o=0, line_len_vld_o=0.
- Output: pkt_o.tvalid = buf_valid. pkt_o.tdata = pixels phase*PX_PER_CLK … phase*PX_PER_CLK+PX_PER_CLK-1 of buf_data, lowest pixel in the LSBs. pkt_o.tlast = buf_last && phase==NPH-1.
- The output mux is driven from registers only; it has no combinational path from pkt_i.
- Ready rule: pkt_i.tready = !buf_valid || (pkt_o.tready && phase==NPH-1). The single combinational path is pkt_o.tready→pkt_i.tready.
- On pkt_o handshake:
  - phase<NPH-1: phase++.
  - phase==NPH-1: phase←0, buf_valid←0, unless a new input is accepted in the same cycle.
- On pkt_i handshake: buf_data←tdata, buf_last←tlast, buf_valid←1, phase←0.
- Simultaneous last-phase output and new input: the buffer reloads and buf_valid stays 1. This gives full throughput (one input per NPH cycles) with no bubble.
- Latency: the first output beat is valid 1 cycle after input acceptance.
- Output stall: tdata and tlast stay stable while tvalid=1 and tready=0 (AXI-Stream rule); phase does not advance.
- Input tvalid low: buf_valid drops after the last phase; no spurious beats.
- Reset mid-packet: the partial group is discarded, the next accepted word is treated as phase 0, and no tlast is emitted for the aborted packet.
- Lines are assumed to be a multiple of 4 pixels (RAW10 CSI-2 constraint); there is no partial-group support.

Optional Feature:
- Macro: RAW10_LINE_CNT_EN.
- With the macro defined:
  - 16-bit pixel counter increments by PX_PER_CLK on every pkt_o handshake.
  - On a handshake with tlast=1: line_len_o ← count+PX_PER_CLK, line_len_vld_o=1 for one cycle, counter←0.
  - The counter saturates at 0xFFFF.
  - Reset clears the counter and both outputs.
- Without the macro: the counter, line_len_o and line_len_vld_o are absent; the datapath is unchanged.

Test Plan:
- PX_PER_CLK=1, pkt_o.tready=1, one input word tdata=0x63_55AA_00FF with tlast=1 → output beats 0x3FF, 0x000, 0x2AA, 0x155 on 4 consecutive cycles, starting 1 cycle after acceptance; tlast only on 0x155. pkt_i.tready=0 for cycles 1–3 and high again in the 0x155 cycle.
- PX_PER_CLK=4, same word → a single beat with fields [9:0]=0x3FF, [19:10]=0x000, [29:20]=0x2AA, [39:30]=0x155, tlast=1. Back-to-back input words give one output beat per cycle with no bubbles.
- PX_PER_CLK=2, pkt_o.tready toggling 1010… over a 3-word line → 6 beats in order, data and tlast held stable during stalls. pkt_i.tready is asserted only in cycles where phase==1 and pkt_o.tready=1 (or the buffer is empty).
- PX_PER_CLK=1, rst_i asserted for 1 cycle after the 2nd output pixel of a group → pkt_o.tvalid=0 the next cycle; the next input word restarts at pixel 0 with correct values; no stale tlast.
- With RAW10_LINE_CNT_EN, PX_PER_CLK=4, a 1920-pixel line (480 words, tlast on the final word) → line_len_o=1920 with a single-cycle line_len_vld_o pulse. A following 8-pixel line gives line_len_o=8.
- Input tvalid gaps of random length, PX_PER_CLK=1, 64 words → the output pixel sequence matches a reference unpacking exactly; no duplicated or dropped pixels.
